// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
//   spi_s_state_t : slave FSM states
//   SPI_DATA_W    : default frame length
//   SPI_*_RST     : reset levels of the synchronized SPI pins
package spi_pkg;

    localparam int SPI_DATA_W = 32;

    localparam logic SPI_CS_N_RST = 1'b1;
    localparam logic SPI_SCLK_RST = 1'b0;
    localparam logic SPI_MOSI_RST = 1'b0;

    typedef enum logic [1:0] {
        WAIT_CS = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2
    } spi_s_state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: brings one asynchronous pin into the clk domain and detects edges.
//   SYNC_STAGES : synchronizer depth (>= 2)
//   RST_LVL     : value every flop takes in reset
//   clk, rst_n  : system clock, synchronous active-low reset
//   pin         : asynchronous input
//   lvl         : synchronized level
//   rise, fall  : one-cycle edge strobes, from lvl versus the history flop
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_LVL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_LVL}};
            hist_q <= RST_LVL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~hist_q;
    assign fall = ~lvl & hist_q;

endmodule

// File: rtl/spi_s.sv
// spi_s: SPI mode-0 slave, MSB first, fixed DATA_W-bit frames framed by cs_n.
// All SPI pins are oversampled in the clk domain.
//   clk, rst_n          : system clock, synchronous active-low reset
//   sclk, cs_n, mosi    : asynchronous SPI pins from the master
//   miso, miso_oe       : slave data out and pad output enable
//   tx_data/valid/ready : one-entry transmit buffer write port
//   rx_data, rx_valid   : last complete received word, one-cycle update strobe
//   frame_err           : pulse, cs_n released mid-frame
//   tx_underrun         : pulse, frame started with the transmit buffer empty
//   busy                : high while shifting a frame
// Build option: SPI_S_ECHO_EN makes an underrun frame send the last received
// word instead of zeros.
//
// state   | meaning
// WAIT_CS | frame done or after reset; wait until cs_n is seen high
// IDLE    | deselected, armed for a cs_n fall
// SHIFT   | frame in progress
module spi_s
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(SPI_CS_N_RST)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin(cs_n),
        .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(SPI_SCLK_RST)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin(sclk),
        .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(SPI_MOSI_RST)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .pin(mosi),
        .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_s_state_t        state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   tx_shift;
    // Only DATA_W-1 bits are kept; the last bit goes straight into rx_data.
    logic [DATA_W-2:0]   rx_shift;
    logic [DATA_W-1:0]   buf_data;
    logic                buf_full;
    logic [DATA_W-1:0]   fallback;
    // The cs_n synchronizer resets to "deselected", so right after reset its
    // level is not the real pin yet. warm_q fills with ones until the chain
    // has been flushed with post-reset samples; WAIT_CS does not trust
    // cs_lvl before that, so a select held low through reset is not taken
    // as a fresh frame.
    logic [SYNC_STAGES:0] warm_q;

`ifdef SPI_S_ECHO_EN
    assign fallback = rx_data;
`else
    assign fallback = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= WAIT_CS;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            warm_q      <= '0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};

            // A write needs the buffer empty and a consume needs it full, so
            // the two never collide; a write landing on a frame start is
            // simply kept for the next frame.
            if (tx_valid && !buf_full) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end

            case (state)
                WAIT_CS: begin
                    if (warm_q[SYNC_STAGES] && cs_lvl) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        if (buf_full) begin
                            tx_shift <= buf_data;
                            buf_full <= 1'b0;
                        end else begin
                            tx_shift    <= fallback;
                            tx_underrun <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[DATA_W-3:0], mosi_lvl};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            rx_data  <= {rx_shift, mosi_lvl};
                            rx_valid <= 1'b1;
                            state    <= WAIT_CS;
                        end
                    end else if (sclk_fall) begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                default: state <= WAIT_CS;
            endcase
        end
    end

    // miso is the MSB of a register, so it holds when deselected and is 0 in reset.
    assign miso     = tx_shift[DATA_W-1];
    assign miso_oe  = ~cs_lvl;
    assign tx_ready = ~buf_full;
    assign busy     = (state == SHIFT);

endmodule

// File: tb/tb_spi_s.sv
module tb_spi_s;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         miso, miso_oe, tx_ready, rx_valid, frame_err, tx_underrun, busy;
    logic [W-1:0] rx_data;

    spi_s #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rv_cnt = 0, fe_cnt = 0, ur_cnt = 0;

    // Counting high cycles: a pulse stretched past one cycle shows up as an extra count.
    always @(negedge clk) begin
        if (rx_valid)    rv_cnt++;
        if (frame_err)   fe_cnt++;
        if (tx_underrun) ur_cnt++;
    end

    // Reference model: last received word and the one-entry transmit buffer.
    logic [W-1:0] m_rx = '0;
    bit           m_full = 0;
    logic [W-1:0] m_buf = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_start(output logic [W-1:0] word, output bit ur);
        if (m_full) begin
            word = m_buf;
            ur = 0;
            m_full = 0;
        end else begin
`ifdef SPI_S_ECHO_EN
            word = m_rx;
`else
            word = '0;
`endif
            ur = 1;
        end
    endtask

    task automatic push(input logic [W-1:0] word);
        check("tx_ready_before_push", {31'b0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_data = word;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        m_full = 1;
        m_buf = word;
        check("tx_ready_after_push", {31'b0, tx_ready}, 32'd0);
    endtask

    // Acts as the SPI master: sclk low phase 6 clk, high phase 4 clk.
    task automatic xfer(input logic [W-1:0] word, input int npulses, input bit inj,
                        input logic [W-1:0] inj_word, output logic [W-1:0] got);
        got = '0;
        @(negedge clk);
        cs_n = 1'b0;
        mosi = word[W-1];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (inj) begin
                tx_valid = (i == 1);
                tx_data = inj_word;
            end
        end
        for (int b = 0; b < npulses; b++) begin
            if (b > 0) wait_clk(6);
            if (b < W) got[W-1-b] = miso;
            if (b == 0) begin
                check("miso_oe_selected", {31'b0, miso_oe}, 32'd1);
                check("busy_in_frame", {31'b0, busy}, 32'd1);
            end
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            if (b + 1 < W) mosi = word[W-2-b];
            else mosi = 1'($urandom);
        end
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic run_frame(input logic [W-1:0] word, input int npulses, input bit inj,
                             input logic [W-1:0] inj_word);
        logic [W-1:0] exp_miso, got;
        bit exp_ur, full;
        int rv0, fe0, ur0;
        model_start(exp_miso, exp_ur);
        if (inj) begin
            m_full = 1;
            m_buf = inj_word;
        end
        full = (npulses >= W);
        rv0 = rv_cnt; fe0 = fe_cnt; ur0 = ur_cnt;
        xfer(word, npulses, inj, inj_word, got);
        if (full) m_rx = word;
        check("rx_valid_pulses", 32'(rv_cnt - rv0), full ? 32'd1 : 32'd0);
        check("frame_err_pulses", 32'(fe_cnt - fe0), full ? 32'd0 : 32'd1);
        check("tx_underrun_pulses", 32'(ur_cnt - ur0), exp_ur ? 32'd1 : 32'd0);
        check("rx_data", rx_data, m_rx);
        if (full) check("miso_word", got, exp_miso);
        check("tx_ready_after_frame", {31'b0, tx_ready}, m_full ? 32'd0 : 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit busy_seen;
        int rv0, fe0;
        logic [W-1:0] w;

        wait_clk(4);
        check("rst_miso", {31'b0, miso}, 32'd0);
        check("rst_miso_oe", {31'b0, miso_oe}, 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_tx_underrun", {31'b0, tx_underrun}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        wait_clk(8);

        push(32'h12345678);
        run_frame(32'hAAAAAAAA, W, 0, '0);

        run_frame($urandom, 10, 0, '0);
        run_frame(32'h0F0F0F0F, W, 0, '0);

        push($urandom);
        run_frame(32'hDEADBEEF, W, 0, '0);
        run_frame($urandom, W, 0, '0);

        run_frame($urandom, W, 1, 32'hCAFEF00D);
        run_frame($urandom, W, 0, '0);

        // Reset in the middle of a frame with cs_n kept low.
        rv0 = rv_cnt; fe0 = fe_cnt;
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1; wait_clk(4); sclk = 1'b0; wait_clk(6);
        end
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        m_rx = '0;
        m_full = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
            sclk = ((i % 10) >= 6);
        end
        sclk = 1'b0;
        check("busy_after_mid_reset", {31'b0, busy_seen}, 32'd0);
        check("rx_valid_mid_reset", 32'(rv_cnt - rv0), 32'd0);
        check("rx_data_mid_reset", rx_data, 32'd0);
        cs_n = 1'b1;
        wait_clk(10);
        check("frame_err_mid_reset", 32'(fe_cnt - fe0), 32'd0);
        run_frame(32'h55AA55AA, W, 0, '0);

        push($urandom);
        run_frame($urandom, W + 4, 0, '0);

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) push($urandom);
            w = $urandom;
            if ($urandom_range(0, 3) == 0) run_frame(w, $urandom_range(1, W - 1), 0, '0);
            else run_frame(w, W, 0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
